// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for the UART transmitter: push request, overflow clear,
// FIFO status flags, frame-done pulse and the serial line.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
) ();
  logic               tx_wr;
  logic [7:0]         tx_data;
  logic               ovf_clr;
  logic               tx_full;
  logic               tx_empty;
  logic [FIFO_AW:0]   tx_count;
  logic               tx_busy;
  logic               tx_done;
  logic               overflow;
  logic               uart_txd;

  modport master (
    output tx_wr, tx_data, ovf_clr,
    input  tx_full, tx_empty, tx_count, tx_busy, tx_done, overflow, uart_txd
  );

  modport slave (
    input  tx_wr, tx_data, ovf_clr,
    output tx_full, tx_empty, tx_count, tx_busy, tx_done, overflow, uart_txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: a 2**FIFO_AW byte FIFO feeding an 8N1 serialiser with
// back-to-back frames, sticky overflow and a registered end-of-frame pulse.
module uart_tx_fifo #(
  parameter int BAUD_DIV = 5208,
  parameter int FIFO_AW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  uart_tx_fifo_if.slave bus
);
  localparam int          DEPTH     = 2 ** FIFO_AW;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           sh_q, sh_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [FIFO_AW-1:0]   wp_q, wp_d;
  logic [FIFO_AW-1:0]   rp_q, rp_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [7:0]           mem_q [DEPTH];

  logic full;
  logic push_ok;
  logic pop;
  logic bit_end;

  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign push_ok = bus.tx_wr && !full;
  assign bit_end = (cnt_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = mem_q[rp_q];
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            sh_d    = mem_q[rp_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is decoded from the next state so txd leaves a flop.
    if (state_d == DATA) txd_d = sh_d[0];
    else                 txd_d = (state_d != START);
  end

  always_comb begin
    wp_d    = push_ok ? wp_q + FIFO_AW'(1) : wp_q;
    rp_d    = pop     ? rp_q + FIFO_AW'(1) : rp_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A rejected push wins over a clear on the same edge.
    if (bus.tx_wr && full) ovf_d = 1'b1;
    else if (bus.ovf_clr)  ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    if (push_ok) mem_q[wp_q] <= bus.tx_data;
  end

  assign bus.tx_full  = full;
  assign bus.tx_empty = (count_q == '0);
  assign bus.tx_count = count_q;
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.overflow = ovf_q;
  assign bus.uart_txd = txd_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a BAUD_DIV=4 instance for framing, FIFO
// and reset cases, and a BAUD_DIV=1 instance for the single-clock-bit case.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  uart_tx_fifo_if #(.FIFO_AW(2)) bus_a ();
  uart_tx_fifo_if #(.FIFO_AW(2)) bus_b ();

  uart_tx_fifo #(.BAUD_DIV(4), .FIFO_AW(2)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.slave));
  uart_tx_fifo #(.BAUD_DIV(1), .FIFO_AW(2)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.slave));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line levels in time order, start bit in [9]
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic txd_of(input bit b);
    return b ? bus_b.uart_txd : bus_a.uart_txd;
  endfunction

  function automatic logic done_of(input bit b);
    return b ? bus_b.tx_done : bus_a.tx_done;
  endfunction

  task automatic check_idle(input bit b, input string nm);
    chk({nm, " txd"},   txd_of(b), 1);
    chk({nm, " busy"},  b ? bus_b.tx_busy  : bus_a.tx_busy, 0);
    chk({nm, " done"},  done_of(b), 0);
    chk({nm, " ovf"},   b ? bus_b.overflow : bus_a.overflow, 0);
    chk({nm, " empty"}, b ? bus_b.tx_empty : bus_a.tx_empty, 1);
    chk({nm, " full"},  b ? bus_b.tx_full  : bus_a.tx_full, 0);
    chk({nm, " count"}, b ? bus_b.tx_count : bus_a.tx_count, 0);
  endtask

  // Entered on the first start-bit cycle; leaves on the tx_done cycle.
  task automatic check_frame(input bit b, input int bd, input logic [9:0] exp, input string nm);
    int errs;
    for (int i = 0; i < 10; i++) begin
      errs = 0;
      for (int c = 0; c < bd; c++) begin
        if (txd_of(b) !== exp[9-i]) errs++;
        if (!(i == 0 && c == 0) && done_of(b) !== 1'b0) errs++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d bad_cycles", nm, i), errs, 0);
    end
    chk({nm, " done"}, done_of(b), 1);
  endtask

  task automatic push_a(input logic [7:0] d);
    bus_a.tx_wr = 1'b1; bus_a.tx_data = d;
    @(negedge clk);
    bus_a.tx_wr = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    bus_b.tx_wr = 1'b1; bus_b.tx_data = d;
    @(negedge clk);
    bus_b.tx_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    vecs[0] = '{8'h55, 10'b0101010101};
    vecs[1] = '{8'hA3, 10'b0110001011};
    vecs[2] = '{8'h0F, 10'b0111100001};
    vecs[3] = '{8'h80, 10'b0000000011};
    vecs[4] = '{8'h01, 10'b0100000001};

    bus_a.tx_wr = 0; bus_a.tx_data = 0; bus_a.ovf_clr = 0;
    bus_b.tx_wr = 0; bus_b.tx_data = 0; bus_b.ovf_clr = 0;
    rst_a = 1; rst_b = 1;
    repeat (2) @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    rst_a = 0; rst_b = 0;
    @(negedge clk);

    // Single frames from the table
    for (int v = 0; v < 5; v++) begin
      push_a(vecs[v].data);
      chk($sformatf("v%0d count_after_push", v), bus_a.tx_count, 1);
      chk($sformatf("v%0d txd_before_start", v), bus_a.uart_txd, 1);
      chk($sformatf("v%0d busy_before_pop", v), bus_a.tx_busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d busy_after_pop", v), bus_a.tx_busy, 1);
      chk($sformatf("v%0d count_after_pop", v), bus_a.tx_count, 0);
      check_frame(0, 4, vecs[v].frame, $sformatf("v%0d", v));
      chk($sformatf("v%0d busy_end", v), bus_a.tx_busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d done_single", v), bus_a.tx_done, 0);
      chk($sformatf("v%0d empty", v), bus_a.tx_empty, 1);
    end

    // Back-to-back frames
    push_a(8'hA3);
    push_a(8'h0F);
    check_frame(0, 4, 10'b0110001011, "b2b_a3");
    check_frame(0, 4, 10'b0111100001, "b2b_0f");
    @(negedge clk);
    check_idle(0, "b2b_end");

    // Fill past capacity, overflow set/clear, ordered drain
    fork
      begin
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        push_a(8'h44); push_a(8'h55); push_a(8'h66);
        chk("ovf_full", bus_a.tx_full, 1);
        chk("ovf_set", bus_a.overflow, 1);
        chk("ovf_count", bus_a.tx_count, 4);
        bus_a.ovf_clr = 1; @(negedge clk); bus_a.ovf_clr = 0;
        chk("ovf_clr", bus_a.overflow, 0);
        bus_a.ovf_clr = 1; push_a(8'h77); bus_a.ovf_clr = 0;
        chk("ovf_clr_vs_push", bus_a.overflow, 1);
        chk("ovf_count2", bus_a.tx_count, 4);
        bus_a.ovf_clr = 1; @(negedge clk); bus_a.ovf_clr = 0;
        chk("ovf_clr2", bus_a.overflow, 0);
      end
      begin
        repeat (2) @(negedge clk);
        check_frame(0, 4, 10'b0100010001, "q11");
        check_frame(0, 4, 10'b0010001001, "q22");
        check_frame(0, 4, 10'b0110011001, "q33");
        check_frame(0, 4, 10'b0001000101, "q44");
        check_frame(0, 4, 10'b0101010101, "q55");
      end
    join
    @(negedge clk);
    check_idle(0, "drain_end");

    // Reset in DATA bit 3 with two bytes queued
    push_a(8'h00); push_a(8'hBB); push_a(8'hCC);
    repeat (16) @(negedge clk);
    chk("mid_txd_bit3", bus_a.uart_txd, 0);
    chk("mid_count", bus_a.tx_count, 2);
    chk("mid_busy", bus_a.tx_busy, 1);
    #1 rst_a = 1;
    #1;
    chk("arst_txd", bus_a.uart_txd, 1);
    chk("arst_count", bus_a.tx_count, 0);
    chk("arst_busy", bus_a.tx_busy, 0);
    chk("arst_empty", bus_a.tx_empty, 1);
    @(negedge clk);
    rst_a = 0;
    errs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus_a.uart_txd !== 1'b1 || bus_a.tx_busy !== 1'b0 || bus_a.tx_done !== 1'b0) errs++;
    end
    chk("post_rst_quiet_cycles", errs, 0);

    // Push while full on the same edge as a pop
    push_a(8'h01); push_a(8'h02); push_a(8'h03); push_a(8'h04); push_a(8'h05);
    chk("pp_full", bus_a.tx_full, 1);
    chk("pp_count4", bus_a.tx_count, 4);
    repeat (36) @(negedge clk);
    chk("pp_no_done_yet", bus_a.tx_done, 0);
    push_a(8'hEE);
    chk("pp_done", bus_a.tx_done, 1);
    chk("pp_ovf", bus_a.overflow, 1);
    chk("pp_count3", bus_a.tx_count, 3);
    chk("pp_not_full", bus_a.tx_full, 0);
    repeat (165) @(negedge clk);
    chk("pp_drain_empty", bus_a.tx_empty, 1);
    chk("pp_drain_busy", bus_a.tx_busy, 0);

    // BAUD_DIV=1, then a push on the tx_done cycle
    push_b(8'hFF);
    chk("b1_txd_before", bus_b.uart_txd, 1);
    @(negedge clk);
    check_frame(1, 1, 10'b0111111111, "b1_ff");
    chk("b1_busy_done", bus_b.tx_busy, 0);
    push_b(8'h5A);
    chk("b1_txd_idle", bus_b.uart_txd, 1);
    chk("b1_count1", bus_b.tx_count, 1);
    chk("b1_busy_idle", bus_b.tx_busy, 0);
    @(negedge clk);
    chk("b1_busy_start", bus_b.tx_busy, 1);
    check_frame(1, 1, 10'b0010110101, "b1_5a");
    @(negedge clk);
    check_idle(1, "b1_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
